// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM state encoding,
// key code constants, matrix width and the (row, col) -> code lookup.
package keypad_scanner_pkg;

  localparam int unsigned KP_W   = 4;
  localparam int unsigned CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam logic [CODE_W-1:0] KEY_A    = 4'd10;
  localparam logic [CODE_W-1:0] KEY_B    = 4'd11;
  localparam logic [CODE_W-1:0] KEY_C    = 4'd12;
  localparam logic [CODE_W-1:0] KEY_D    = 4'd13;
  localparam logic [CODE_W-1:0] KEY_STAR = 4'd14;
  localparam logic [CODE_W-1:0] KEY_HASH = 4'd15;

  // Keypad legend: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic logic [CODE_W-1:0] key_lookup(input logic [1:0] r,
                                                   input logic [1:0] c);
    logic [CODE_W-1:0] code;
    code = 4'd0;
    case ({r, c})
      4'h0:    code = 4'd1;
      4'h1:    code = 4'd2;
      4'h2:    code = 4'd3;
      4'h3:    code = KEY_A;
      4'h4:    code = 4'd4;
      4'h5:    code = 4'd5;
      4'h6:    code = 4'd6;
      4'h7:    code = KEY_B;
      4'h8:    code = 4'd7;
      4'h9:    code = 4'd8;
      4'hA:    code = 4'd9;
      4'hB:    code = KEY_C;
      4'hC:    code = KEY_STAR;
      4'hD:    code = 4'd0;
      4'hE:    code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational decode of one row sample.
// Ports: row_idx - row currently driven; col - synchronized active-low
// column returns; hit - any key pressed in this row; code - key code of the
// lowest-numbered pressed column (0 when no hit).
module keypad_decode
  import keypad_scanner_pkg::*;
(
  input  logic [1:0]        row_idx,
  input  logic [KP_W-1:0]   col,
  output logic              hit,
  output logic [CODE_W-1:0] code
);

  logic [1:0] first_col;

  // Scan from the top so the lowest pressed column wins.
  always_comb begin
    hit       = 1'b0;
    first_col = 2'd0;
    for (int c = KP_W - 1; c >= 0; c--) begin
      if (!col[c]) begin
        hit       = 1'b1;
        first_col = 2'(c);
      end
    end
    code = hit ? key_lookup(row_idx, first_col) : 4'd0;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with scan-based debounce.
// Ports: clk - system clock; rst - synchronous active-high reset;
// row - active-low row strobes (one low at a time); col - active-low column
// returns (asynchronous); key_code - last confirmed key; key_valid - one-cycle
// pulse on a newly confirmed press; key_held - high while that key is held.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [KP_W-1:0]   row,
  input  logic [KP_W-1:0]   col,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

  logic [KP_W-1:0]   col_s1, col_s2;
  logic              scan_en;
  logic [CNT_W-1:0]  div_cnt;
  logic [1:0]        row_idx;
  logic              acc_hit;
  logic [CODE_W-1:0] acc_code;
  state_t            state;
  logic [CODE_W-1:0] cand_reg;
  logic [3:0]        cnt;
  logic [3:0]        rel_cnt;

  logic              dec_hit;
  logic [CODE_W-1:0] dec_code;
  logic              sample_c;
  logic              scan_end_c;
  logic              cand_hit_c;
  logic [CODE_W-1:0] cand_code_c;
  logic [1:0]        next_row_c;

  // Two-flop synchronizer for the asynchronous column returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
    end else begin
      col_s1 <= col;
      col_s2 <= col_s1;
    end
  end

  assign next_row_c = row_idx + 2'd1;

  // Row scan; scan_en delays the counter one cycle so that a full
  // period of row 0 follows the release of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_en <= 1'b0;
      div_cnt <= '0;
      row_idx <= 2'd0;
      row     <= 4'b1111;
    end else if (!scan_en) begin
      scan_en <= 1'b1;
      row     <= 4'b1110;
    end else if (div_cnt == CNT_LAST) begin
      div_cnt <= '0;
      row_idx <= next_row_c;
      row     <= ~(4'b0001 << next_row_c);
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  assign sample_c   = scan_en && (div_cnt == CNT_LAST);
  assign scan_end_c = sample_c && (row_idx == 2'd3);

  keypad_decode u_decode (
    .row_idx (row_idx),
    .col     (col_s2),
    .hit     (dec_hit),
    .code    (dec_code)
  );

  // First hit of the scan in progress; row 0 restarts accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hit  <= 1'b0;
      acc_code <= '0;
    end else if (sample_c && ((row_idx == 2'd0) || !acc_hit)) begin
      acc_hit  <= dec_hit;
      acc_code <= dec_code;
    end
  end

  // Full-scan candidate including the row-3 sample taken this cycle.
  assign cand_hit_c  = acc_hit | dec_hit;
  assign cand_code_c = acc_hit ? acc_code : dec_code;

  // Debounce / hold FSM, advanced once per completed scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cand_reg  <= '0;
      cnt       <= 4'd0;
      rel_cnt   <= 4'd0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scan_end_c) begin
        case (state)
          IDLE: begin
            if (cand_hit_c) begin
              cand_reg <= cand_code_c;
              if (DB_N == 4'd1) begin
                key_code  <= cand_code_c;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                cnt       <= 4'd0;
                rel_cnt   <= 4'd0;
                state     <= HELD;
              end else begin
                cnt   <= 4'd1;
                state <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (cand_hit_c && (cand_code_c == cand_reg)) begin
              if ((cnt + 4'd1) == DB_N) begin
                key_code  <= cand_reg;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                cnt       <= 4'd0;
                rel_cnt   <= 4'd0;
                state     <= HELD;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end else begin
              cnt   <= 4'd0;
              state <= IDLE;
            end
          end
          HELD: begin
            // Any key, even a different one, keeps the hold alive.
            if (cand_hit_c) begin
              rel_cnt <= 4'd0;
            end else if ((rel_cnt + 4'd1) == DB_N) begin
              rel_cnt  <= 4'd0;
              key_held <= 1'b0;
              state    <= IDLE;
            end else begin
              rel_cnt <= rel_cnt + 4'd1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000, meaning clk cycles each row is driven; legal range 4 to 2^20.
REQ-002 Parameter DEBOUNCE_SCANS, default 4, meaning consecutive identical full scans that confirm a press or a release; legal range 1 to 15.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 row  output  4  keypad row strobes, active-low; at most one bit low at any time.
REQ-006 col  input  4  keypad column returns, active-low, externally pulled up; asynchronous to clk.
REQ-007 key_code  output  4  code of the last confirmed key.
REQ-008 key_valid  output  1  one-cycle pulse when a new press is confirmed.
REQ-009 key_held  output  1  high while the confirmed key is considered held.

Function
REQ-010 col SHALL pass through a 2-flop synchronizer before any use.
REQ-011 Row scan: row period counter 0..SCAN_DIV-1; row index r advances 0,1,2,3 and wraps to 0; row drives low only bit r.
REQ-012 Synchronized columns SHALL be sampled only on the last cycle of each row period (count = SCAN_DIV-1).
REQ-013 Scan end is the last cycle of the row-3 period; the candidate is the first pressed key in scan order (row 0 to 3, col 0 to 3 within a row); otherwise the result is "none".
REQ-014 Multiple simultaneous keys: the candidate is the first in scan order; no error flag exists.
REQ-015 Code map (row,col): (0,0..3)=1,2,3,A; (1,*)=4,5,6,B; (2,*)=7,8,9,C; (3,*)=*,0,#,D. Digits encode to their value, A-D to 10-13, * to 14, # to 15.
REQ-016 FSM states IDLE, DEBOUNCE, HELD; transitions are evaluated only at scan end.
REQ-017 IDLE: candidate present -> DEBOUNCE, cand_reg=candidate, cnt=1; if DEBOUNCE_SCANS=1, go directly to confirmation (REQ-019).
REQ-018 DEBOUNCE: candidate equals cand_reg -> cnt+1; candidate differs or is none -> IDLE, cnt=0, no pulse.
REQ-019 Confirmation: when cnt reaches DEBOUNCE_SCANS, key_code<=cand_reg, key_valid=1 in the cycle after that scan end, key_held=1, state -> HELD.
REQ-020 HELD: a scan with result none -> rel_cnt+1; any key present -> rel_cnt=0. rel_cnt reaching DEBOUNCE_SCANS -> IDLE, key_held=0.
REQ-021 HELD: a different key never produces key_valid until the release completes; no auto-repeat.
REQ-022 key_code holds its value after release until the next confirmation.
REQ-023 Counters SHALL saturate or be cleared, never wrap: cnt and rel_cnt are 4-bit, and the row-period counter is ceil(log2 SCAN_DIV) bits.

Reset
REQ-024 While rst=1: row=4'b1111, key_code=0, key_valid=0, key_held=0, state=IDLE, all counters=0, synchronizer flops=4'b1111.
REQ-025 Reset mid-press discards any debounce progress; no key_valid pulse is emitted.
REQ-026 In the first cycle after rst falls, row=4'b1110 and a full SCAN_DIV period starts.

Structure
REQ-027 The shared package holds the FSM state encoding (IDLE=0, DEBOUNCE=1, HELD=2), the KEY_A..KEY_HASH code constants, and the row/col width constant 4.
REQ-028 One sub-module, keypad_decode: combinational (row index, col vector) -> (hit, code) used at each sample point.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2)
REQ-029 Row sequence: after reset, observe row = 1110,1101,1011,0111 with 4 cycles each, then wrap to 1110.
REQ-030 Hold key "5" (row1,col1) for 3 scans -> exactly one key_valid pulse, key_code=5, key_held=1; release for 2 scans -> key_held=0.
REQ-031 "8" pressed for 1 scan only -> no key_valid, state returns to IDLE, key_code unchanged.
REQ-032 Press "1" and "D" together -> key_code=1; while holding "1", pressing "#" -> no new pulse.
REQ-033 Assert rst during DEBOUNCE of "0" -> no pulse, outputs at reset values, rows all 1111.
REQ-034 Press "#" -> key_code=15; release; press "*" -> key_code=14; exactly two pulses total.
